// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a local payload, then streams header, payload and parity to the 1x3 router.
// Optional ROUTER_TX_PARITY_CORRUPT_EN adds input corrupt_par, which sends the parity byte inverted.
module router_pkt_tx #(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [1:0]       tx_addr,
  input  logic [5:0]       tx_len,
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
  input  logic             corrupt_par,
`endif
  output logic             tx_idle,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             pkt_valid,
  output logic [7:0]       data_out,
  input  logic             busy,
  input  logic             err,
  output logic             tx_done,
  output logic             tx_rej,
  output logic             pkt_err,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_HDR, S_PLD, S_PAR, S_GAP} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_buf [64];
  logic [5:0]       r_wrIdx;
  logic [5:0]       r_rdIdx;
  logic [5:0]       r_len;
  logic [1:0]       r_addr;
  logic [7:0]       r_parity;
  logic [GW-1:0]    r_gapCnt;
  logic             r_pktValid;
  logic [7:0]       r_dataOut;
  logic             r_txDone;
  logic             r_txRej;
  logic             r_pktErr;
  logic             r_txIdle;
  logic [CNT_W-1:0] r_pktCnt;
  logic             w_startOk;
  logic             w_lastWr;
  logic             w_lastRd;
  logic             w_gapEnd;
  logic             w_accept;
  logic [7:0]       w_header;
  logic [7:0]       w_parOut;

  assign w_startOk = tx_start && (tx_addr != 2'd3) && (tx_len != 6'd0);
  assign w_lastWr  = s_valid && (r_wrIdx == r_len - 6'd1);
  assign w_lastRd  = (r_rdIdx == r_len - 6'd1);
  assign w_gapEnd  = (r_gapCnt == GW'(GAP_CYCLES - 1));
  assign w_accept  = !busy;
  assign w_header  = {r_len, r_addr};

`ifdef ROUTER_TX_PARITY_CORRUPT_EN
  logic r_corrupt;
  assign w_parOut = r_corrupt ? ~r_parity : r_parity;
`else
  assign w_parOut = r_parity;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_startOk)             w_nextState = S_FILL;
      S_FILL:  if (w_lastWr)              w_nextState = S_HDR;
      S_HDR:   if (w_accept)              w_nextState = S_PLD;
      S_PLD:   if (w_accept && w_lastRd)  w_nextState = S_PAR;
      S_PAR:   if (w_accept)              w_nextState = S_GAP;
      S_GAP:   if (w_gapEnd)              w_nextState = S_IDLE;
      default:                            w_nextState = S_IDLE;
    endcase
  end

  // Payload storage has no reset; its contents only matter after a full fill.
  always_ff @(posedge clk) begin
    if (r_state == S_FILL && s_valid) r_buf[r_wrIdx] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pktValid <= 1'b0;
      r_dataOut  <= 8'd0;
      r_txDone   <= 1'b0;
      r_txRej    <= 1'b0;
      r_pktErr   <= 1'b0;
      r_pktCnt   <= '0;
      r_txIdle   <= 1'b1;
      r_wrIdx    <= 6'd0;
      r_rdIdx    <= 6'd0;
      r_len      <= 6'd0;
      r_addr     <= 2'd0;
      r_parity   <= 8'd0;
      r_gapCnt   <= '0;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
      r_corrupt  <= 1'b0;
`endif
    end else begin
      r_txDone <= 1'b0;
      r_txRej  <= 1'b0;
      r_txIdle <= (w_nextState == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            if (w_startOk) begin
              r_len    <= tx_len;
              r_addr   <= tx_addr;
              r_pktErr <= 1'b0;
              r_parity <= {tx_len, tx_addr};
              r_wrIdx  <= 6'd0;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
              r_corrupt <= corrupt_par;
`endif
            end else begin
              r_txRej <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (s_valid) begin
            r_wrIdx  <= r_wrIdx + 6'd1;
            r_parity <= r_parity ^ s_data;
            if (w_lastWr) begin
              r_dataOut  <= w_header;
              r_pktValid <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (w_accept) begin
            r_dataOut <= r_buf[0];
            r_rdIdx   <= 6'd0;
          end
        end
        S_PLD: begin
          // The parity byte is presented with pkt_valid already low.
          if (w_accept) begin
            if (w_lastRd) begin
              r_pktValid <= 1'b0;
              r_dataOut  <= w_parOut;
            end else begin
              r_rdIdx   <= r_rdIdx + 6'd1;
              r_dataOut <= r_buf[r_rdIdx + 6'd1];
            end
          end
        end
        S_PAR: begin
          if (w_accept) begin
            r_dataOut <= 8'd0;
            r_txDone  <= 1'b1;
            r_pktCnt  <= r_pktCnt + CNT_W'(1);
            r_gapCnt  <= '0;
          end
        end
        S_GAP: begin
          if (err)       r_pktErr <= 1'b1;
          if (!w_gapEnd) r_gapCnt <= r_gapCnt + GW'(1);
        end
        default: ;
      endcase
    end
  end

  assign s_ready   = (r_state == S_FILL);
  assign tx_idle   = r_txIdle;
  assign pkt_valid = r_pktValid;
  assign data_out  = r_dataOut;
  assign tx_done   = r_txDone;
  assign tx_rej    = r_txRej;
  assign pkt_err   = r_pktErr;
  assign pkt_cnt   = r_pktCnt;

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source that drives the 1x3 router's ingress interface.
- Collects a payload from a local byte stream into an internal buffer, then emits a complete router packet without gaps: header {len[5:0], addr[1:0]}, payload bytes, parity byte. It honours the router's busy backpressure.
- Also reports the router's err flag per packet.
- Sits upstream of the router top; used as an on-chip traffic source and as the bench stimulus driver.

Parameters:
- GAP_CYCLES, 2: idle cycles after the parity byte before a new tx_start is accepted; err is sampled during this window (min 1).
- CNT_W, 16: width of the packet counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- tx_start  in  1  request to send one packet; sampled only while tx_idle=1.
- tx_addr  in  2  destination port 0..2; 3 is invalid.
- tx_len  in  6  payload length 1..63; 0 is invalid.
- tx_idle  out  1  block is in IDLE and can take tx_start.
- s_valid  in  1  payload byte valid.
- s_data  in  8  payload byte.
- s_ready  out  1  block accepts a payload byte this cycle.
- pkt_valid  out  1  to router pkt_valid.
- data_out  out  8  to router data_in.
- busy  in  1  router busy; the presented byte is held while busy=1.
- err  in  1  router parity error flag.
- tx_done  out  1  one-cycle pulse when the parity byte is accepted.
- tx_rej  out  1  one-cycle pulse when tx_start has an invalid addr or len.
- pkt_err  out  1  err was seen during the GAP of the last packet; held until the next accepted tx_start.
- pkt_cnt  out  CNT_W  count of completed packets; wraps at 2^CNT_W.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - pkt_valid=0, data_out=0, s_ready=0, tx_done=0, tx_rej=0, pkt_err=0, pkt_cnt=0, tx_idle=1.
  - Buffer contents are don't-care.
  - Reset mid-packet aborts the packet: pkt_valid is low from the next edge, and no tx_done is issued.
- All outputs are registered except s_ready, which is a decode of the state: 1 in FILL only.
- A byte is "accepted" on a clock edge in HDR, PLD or PAR with busy=0.
- While busy=1, data_out and pkt_valid hold their values.
- IDLE:
  - tx_start with addr<=2 and len!=0 → FILL. Latch addr and len, clear pkt_err, parity=header byte.
  - tx_start with addr=3 or len=0 → tx_rej pulse, stay in IDLE.
- FILL:
  - On each s_valid, write s_data to buf[wr_idx], increment wr_idx, and XOR the byte into parity.
  - When the len-th byte is written → HDR; on that edge data_out=header and pkt_valid=1.
- HDR: on accept → PLD, data_out=buf[0].
- PLD:
  - On accept, rd_idx+1 and data_out=buf[rd_idx+1].
  - On accept of buf[len-1] → PAR, with pkt_valid=0 and data_out=parity on the same edge.
  - pkt_valid therefore stays high continuously for exactly len+1 accepted bytes.
- PAR: on accept → GAP. tx_done pulses and pkt_cnt increments; data_out returns to 0.
- GAP:
  - Counts GAP_CYCLES cycles; any err=1 sets pkt_err.
  - At the end of the count → IDLE, tx_idle=1.
- Parity is the 8-bit XOR of the header and all payload bytes.
- The buffer is 64x8. Indices are 6-bit and never wrap, since len<=63.
- tx_start outside IDLE is ignored.
- s_valid outside FILL is ignored.

Optional Feature:
- Macro ROUTER_TX_PARITY_CORRUPT_EN.
- When defined: add input corrupt_par (1 bit), latched at the accepted tx_start. If latched high, the parity byte is sent bit-inverted (~parity), so the router's err path can be tested.
- When undefined: the port is absent and parity is always correct.

Test Plan:
1. addr=1, len=3, payload 0x11,0x22,0x33, busy=0 → data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1 on 4 consecutive cycles, then 0x0D with pkt_valid=0. tx_done pulses once, pkt_cnt=1, pkt_err=0.
2. Same packet with busy=1 for 3 cycles while 0x22 is presented → data_out holds 0x22 and pkt_valid holds 1 for 3 cycles. The sequence otherwise completes unchanged.
3. tx_start with addr=3, and separately with len=0 → tx_rej pulses one cycle each, tx_idle stays 1, pkt_valid never rises.
4. addr=2, len=63, payload 0..62 with s_valid toggling every other cycle → header 0xFE, then 63 contiguous payload bytes, then parity equal to the XOR of all 64 bytes.
5. With ROUTER_TX_PARITY_CORRUPT_EN and corrupt_par=1, packet from test 1 → parity byte 0xF2. err driven high in GAP → pkt_err=1 until the next accepted tx_start.
6. rst=1 while presenting payload byte 2 → next cycle pkt_valid=0, pkt_cnt=0, tx_idle=1, no tx_done. A following normal packet passes as in test 1.
